// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared encodings and default sizes for the data-memory
//               arbiter (FSM states, slot-owner codes, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Default geometry
    localparam int DEF_AW           = 10;
    localparam int DEF_DW           = 32;
    localparam int DEF_LENW         = 5;
    localparam int DEF_STARVE_LIMIT = 8;

    // Arbitration FSM state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;   // no burst latched
    localparam logic [0:0] ST_BURST = 1'b1;   // burst latched, beats remaining

    // Owner of the memory slot in the current cycle
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dmem_burst_ctr
// Description : Burst bookkeeping for the DMA side of the arbiter. Latches
//               the base address and beat count when a burst starts and
//               produces the address of the beat about to issue, the number
//               of beats still to issue (including this one) and a last-beat
//               flag. The first beat issues in the start cycle itself, so
//               during i_start the outputs come straight from the inputs.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_start         - burst start (always coincides with i_beat)
//               i_beat          - a DMA beat issues this cycle
//               i_base, i_len   - burst base address / length (0 means 1)
//               o_addr          - address of the current beat
//               o_remaining     - beats left, counting the current one
//               o_last          - current beat is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int LENW = DEF_LENW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_beat,
    input  logic [AW-1:0]   i_base,
    input  logic [LENW-1:0] i_len,
    output logic [AW-1:0]   o_addr,
    output logic [LENW-1:0] o_remaining,
    output logic            o_last
);

    logic [AW-1:0]   r_base;
    logic [AW-1:0]   r_idx;   // index of the next beat; holds while preempted
    logic [LENW-1:0] r_rem;   // beats still to issue
    logic [LENW-1:0] w_len_eff;

    assign w_len_eff = (i_len == '0) ? LENW'(1) : i_len;

    always_comb begin
        o_addr      = r_base + r_idx;   // wraps modulo 2^AW by width
        o_remaining = r_rem;
        if (i_start) begin
            o_addr      = i_base;
            o_remaining = w_len_eff;
        end
        o_last = (o_remaining == LENW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_idx  <= '0;
            r_rem  <= '0;
        end else if (i_beat) begin
            if (i_start) begin
                r_base <= i_base;
                r_idx  <= AW'(1);
            end else begin
                r_idx  <= r_idx + AW'(1);
            end
            r_rem <= o_remaining - LENW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Single-port data-memory arbiter between the CPU MEM stage and
//               the DMA engine. DMA bursts are serialised into single beats;
//               the CPU may take the slot between any two beats. A starvation
//               counter forces a pending DMA beat after STARVE_LIMIT
//               consecutive CPU-won slots.
// Ports       : clk, rst                          - clock, sync active-high reset
//               cpu_req/we/addr/wdata, cpu_rdata  - CPU access, read data
//               cpu_stall                         - cpu_req && !cpu granted
//               dma_req/we/addr/len/wdata         - DMA burst request
//               dma_gnt, dma_beat                 - burst start / beat issued
//               dma_rvalid, dma_rdata, dma_done   - DMA read return, burst end
//               mem_en/we/addr/wdata, mem_rdata   - memory port (1-cycle read)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int LENW         = DEF_LENW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic            clk,
    input  logic            rst,
    // CPU MEM stage
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_stall,
    // DMA engine
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [AW-1:0]   dma_addr,
    input  logic [LENW-1:0] dma_len,
    input  logic [DW-1:0]   dma_wdata,
    output logic            dma_gnt,
    output logic            dma_beat,
    output logic            dma_rvalid,
    output logic [DW-1:0]   dma_rdata,
    output logic            dma_done,
    // Memory port
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_starve_w-1:0] r_starve_cnt;
    logic [c_starve_w-1:0] w_starve_nxt;
    logic [1:0]            w_owner;
    logic                  w_pending;
    logic                  w_starve_flag;
    logic                  w_start;
    logic                  w_dma_beat;
    logic                  w_burst_we;
    logic                  r_burst_we;
    logic [AW-1:0]         w_beat_addr;
    logic [LENW-1:0]       w_remaining;
    logic                  w_last;
    // Read-return tracking: which side issued a read in the previous cycle
    logic                  r_cpu_rd;
    logic                  r_dma_rd;
    logic                  r_dma_done;
    logic [DW-1:0]         r_cpu_hold;
    logic [DW-1:0]         r_dma_hold;

    dmem_burst_ctr #(
        .AW   (AW),
        .LENW (LENW)
    ) u_burst_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_beat      (w_dma_beat),
        .i_base      (dma_addr),
        .i_len       (dma_len),
        .o_addr      (w_beat_addr),
        .o_remaining (w_remaining),
        .o_last      (w_last)
    );

    // ------------------------------------------------------------------
    // Slot choice, next state and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        w_owner       = OWN_NONE;
        w_state_nxt   = r_state;
        w_starve_nxt  = r_starve_cnt;
        w_pending     = (r_state == ST_BURST) || dma_req;
        w_starve_flag = (r_starve_cnt == c_starve_w'(STARVE_LIMIT));

        if (rst) begin
            w_owner = OWN_NONE;
        end else if (w_starve_flag && w_pending) begin
            w_owner = OWN_DMA;
        end else if (cpu_req) begin
            w_owner = OWN_CPU;
        end else if (w_pending) begin
            w_owner = OWN_DMA;   // continue a burst, or start one from IDLE
        end

        w_dma_beat = (w_owner == OWN_DMA);
        w_start    = w_dma_beat && (r_state == ST_IDLE);
        w_burst_we = w_start ? dma_we : r_burst_we;

        // A single-beat burst never leaves IDLE
        if (w_dma_beat) begin
            w_state_nxt = (w_remaining > LENW'(1)) ? ST_BURST : ST_IDLE;
        end

        if (!w_pending || w_dma_beat) begin
            w_starve_nxt = '0;
        end else if ((w_owner == OWN_CPU) && !w_starve_flag) begin
            w_starve_nxt = r_starve_cnt + c_starve_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_owner)
            OWN_CPU: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                mem_en    = 1'b1;
                mem_we    = w_burst_we;
                mem_addr  = w_beat_addr;
                mem_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_stall  = !rst && cpu_req && (w_owner != OWN_CPU);
    assign dma_gnt    = w_start;
    assign dma_beat   = w_dma_beat;
    assign dma_done   = r_dma_done;
    assign dma_rvalid = r_dma_rd;
    // Memory data is valid the cycle after the grant; outside that cycle
    // each side sees the last word it read.
    assign cpu_rdata  = r_cpu_rd ? mem_rdata : r_cpu_hold;
    assign dma_rdata  = r_dma_rd ? mem_rdata : r_dma_hold;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_burst_we   <= 1'b0;
            r_cpu_rd     <= 1'b0;
            r_dma_rd     <= 1'b0;
            r_dma_done   <= 1'b0;
            r_cpu_hold   <= '0;
            r_dma_hold   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (w_start) begin
                r_burst_we <= dma_we;
            end
            r_cpu_rd   <= (w_owner == OWN_CPU) && !cpu_we;
            r_dma_rd   <= w_dma_beat && !w_burst_we;
            r_dma_done <= w_dma_beat && w_last;
            if (r_cpu_rd) begin
                r_cpu_hold <= mem_rdata;
            end
            if (r_dma_rd) begin
                r_dma_hold <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
